// File: rtl/rv_wb_scoreboard.sv
// ============================================================================
// rv_wb_scoreboard
// ----------------------------------------------------------------------------
// Synthesizable self-checking scoreboard for the single-cycle RISC-V core.
// It sits beside the register-file write port. It keeps an in-order queue of
// expected register writebacks (rd, value) and checks every retired register
// write against the head of that queue. At the end it reports pass/fail, the
// mismatch count, the RUN cycle count, the first mismatch and any timeout.
//
// Optional feature (compile-time macro RV_SB_MASK_EN):
//   When the macro is defined, an exp_mask input is stored with every entry.
//   The data compare then ignores bits where the mask is 0. The rd field is
//   always compared in full, and mm_exp still reports the unmasked data.
//   When the macro is undefined, the port is absent and the compare is exact.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   clear             synchronous flush back to IDLE (priority below reset)
//   exp_valid/ready   expected-entry push handshake (ready only in IDLE)
//   exp_rd, exp_data  expected destination register and value
//   exp_mask          per-entry data compare mask (RV_SB_MASK_EN only)
//   start             begin checking (sampled in IDLE only)
//   timeout           max RUN cycles, 0 disables the timeout
//   wb_en/rd/data     core register-file write port
//   busy, done        state == RUN / state == DONE
//   pass, timed_out   final verdict (valid while done)
//   err_count         saturating mismatch count
//   cycle_count       saturating RUN cycle count
//   mm_valid/rd/got/exp  details of the first mismatch
// ============================================================================
module rv_wb_scoreboard #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int DEPTH = 16,
    parameter int CNT_W = 8,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [RA_W-1:0]  exp_rd,
    input  logic [XLEN-1:0]  exp_data,
`ifdef RV_SB_MASK_EN
    input  logic [XLEN-1:0]  exp_mask,
`endif
    input  logic             start,
    input  logic [CYC_W-1:0] timeout,
    input  logic             wb_en,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timed_out,
    output logic [CNT_W-1:0] err_count,
    output logic [CYC_W-1:0] cycle_count,
    output logic             mm_valid,
    output logic [RA_W-1:0]  mm_rd,
    output logic [XLEN-1:0]  mm_got,
    output logic [XLEN-1:0]  mm_exp
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0]  PTR_ONE   = 1;
    localparam logic [AW:0]    OCC_ONE   = 1;
    localparam logic [AW:0]    OCC_FULL  = DEPTH;
    localparam logic [CNT_W-1:0] ERR_ONE = 1;
    localparam logic [CYC_W-1:0] CYC_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Saturating incrementers for the two counters.
    function automatic logic [CNT_W-1:0] sat_inc_err(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ERR_ONE;
    endfunction

    function automatic logic [CYC_W-1:0] sat_inc_cyc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_ONE;
    endfunction

    // ------------------------------------------------------------------
    // Expected-entry queue storage. Contents are not reset; the pointers
    // and the occupancy count decide which entries are valid.
    // ------------------------------------------------------------------
    logic [RA_W-1:0] q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
`ifdef RV_SB_MASK_EN
    logic [XLEN-1:0] q_mask [DEPTH];
`endif

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;

    logic            full;
    logic            push;
    logic            pop;
    logic            last_pop;
    logic            start_empty;
    logic            tmo_hit;
    logic            rd_ok;
    logic            data_ok;
    logic            mismatch;
    logic [RA_W-1:0] head_rd;
    logic [XLEN-1:0] head_data;
    logic [CNT_W-1:0] err_nxt;

    assign full      = (occ == OCC_FULL);
    assign exp_ready = (state == S_IDLE) && !full;
    assign push      = exp_valid && exp_ready;

    assign head_rd   = q_rd[rd_ptr];
    assign head_data = q_data[rd_ptr];

    // Writes to x0 are not architectural writes, so they never consume
    // an entry. While in RUN the queue is never empty, but the guard is kept
    // so that the pointers cannot underflow.
    assign pop      = (state == S_RUN) && wb_en && (wb_rd != '0) && (occ != '0);
    assign last_pop = pop && (occ == OCC_ONE);

    // Combinational compare against the queue head.
    assign rd_ok = (wb_rd == head_rd);
`ifdef RV_SB_MASK_EN
    assign data_ok = (((wb_data ^ head_data) & q_mask[rd_ptr]) == '0);
`else
    assign data_ok = (wb_data == head_data);
`endif
    assign mismatch = pop && !(rd_ok && data_ok);
    assign err_nxt  = mismatch ? sat_inc_err(err_count) : err_count;

    // A push in the same cycle as start still counts toward the queue.
    assign start_empty = (occ == '0) && !push;

    // If the final pop happens on the timeout cycle, the pop takes precedence.
    assign tmo_hit = (state == S_RUN) && (timeout != '0) &&
                     (cycle_count == (timeout - CYC_ONE)) && !last_pop;

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = start_empty ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_pop || tmo_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (clear) begin
            state_nxt = S_IDLE;
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // ------------------------------------------------------------------
    // Queue storage writes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= exp_rd;
            q_data[wr_ptr] <= exp_data;
`ifdef RV_SB_MASK_EN
            q_mask[wr_ptr] <= exp_mask;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Queue pointers, counters, verdict and first-mismatch capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            err_count   <= '0;
            cycle_count <= '0;
            pass        <= 1'b0;
            timed_out   <= 1'b0;
            mm_valid    <= 1'b0;
            mm_rd       <= '0;
            mm_got      <= '0;
            mm_exp      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase

            if (state == S_RUN) begin
                cycle_count <= sat_inc_cyc(cycle_count);
                err_count   <= err_nxt;
                // Only the first mismatch is captured; later ones just count.
                if (mismatch && !mm_valid) begin
                    mm_valid <= 1'b1;
                    mm_rd    <= wb_rd;
                    mm_got   <= wb_data;
                    mm_exp   <= head_data;
                end
            end

            if ((state == S_IDLE) && start && start_empty) begin
                pass      <= 1'b1;
                timed_out <= 1'b0;
            end else if (last_pop) begin
                pass      <= (err_nxt == '0);
                timed_out <= 1'b0;
            end else if (tmo_hit) begin
                pass      <= 1'b0;
                timed_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv_wb_scoreboard.sv
// Testbench for rv_wb_scoreboard. Expected entries are mirrored into a model
// queue as they are pushed. Each writeback pops the model queue, so the bench
// predicts the error count and the first-mismatch fields on its own. These
// predictions are compared against the DUT when it reports done.
module tb_rv_wb_scoreboard;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int DEPTH = 16;
    localparam int CNT_W = 8;
    localparam int CYC_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             exp_valid;
    logic             exp_ready;
    logic [RA_W-1:0]  exp_rd;
    logic [XLEN-1:0]  exp_data;
    logic [XLEN-1:0]  exp_mask;
    logic             start;
    logic [CYC_W-1:0] timeout;
    logic             wb_en;
    logic [RA_W-1:0]  wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timed_out;
    logic [CNT_W-1:0] err_count;
    logic [CYC_W-1:0] cycle_count;
    logic             mm_valid;
    logic [RA_W-1:0]  mm_rd;
    logic [XLEN-1:0]  mm_got;
    logic [XLEN-1:0]  mm_exp;

    rv_wb_scoreboard #(
        .XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .CYC_W(CYC_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .exp_valid(exp_valid),
        .exp_ready(exp_ready),
        .exp_rd(exp_rd),
        .exp_data(exp_data),
`ifdef RV_SB_MASK_EN
        .exp_mask(exp_mask),
`endif
        .start(start),
        .timeout(timeout),
        .wb_en(wb_en),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .busy(busy),
        .done(done),
        .pass(pass),
        .timed_out(timed_out),
        .err_count(err_count),
        .cycle_count(cycle_count),
        .mm_valid(mm_valid),
        .mm_rd(mm_rd),
        .mm_got(mm_got),
        .mm_exp(mm_exp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] mask;
    } ent_t;

    ent_t            mq[$];
    int              m_err;
    logic            m_mm_v;
    logic [RA_W-1:0] m_mm_rd;
    logic [XLEN-1:0] m_mm_got;
    logic [XLEN-1:0] m_mm_exp;

    int n_cmp = 0;
    int n_bad = 0;

    logic [XLEN-1:0] tdata [8] = '{32'd5, 32'd10, 32'hFFFF_FFF0, 32'd3,
                                   32'd15, 32'hFFFF_FFFB, 32'd0, 32'd15};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        mq.delete();
        m_err    = 0;
        m_mm_v   = 1'b0;
        m_mm_rd  = '0;
        m_mm_got = '0;
        m_mm_exp = '0;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
    endtask

    task automatic push_exp(input logic [RA_W-1:0] rd, input logic [XLEN-1:0] data,
                            input logic [XLEN-1:0] mask);
        ent_t e;
        chk("exp_ready", 64'(exp_ready), 64'(mq.size() < DEPTH));
        exp_valid = 1'b1;
        exp_rd    = rd;
        exp_data  = data;
        exp_mask  = mask;
        e.rd   = rd;
        e.data = data;
`ifdef RV_SB_MASK_EN
        e.mask = mask;
`else
        e.mask = '1;
`endif
        if (mq.size() < DEPTH) mq.push_back(e);
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wb(input logic [RA_W-1:0] rd, input logic [XLEN-1:0] data);
        ent_t e;
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_data = data;
        if (rd != '0 && mq.size() > 0) begin
            e = mq.pop_front();
            if (rd != e.rd || ((data ^ e.data) & e.mask) != '0) begin
                if (m_err < 255) m_err++;
                if (!m_mm_v) begin
                    m_mm_v   = 1'b1;
                    m_mm_rd  = rd;
                    m_mm_got = data;
                    m_mm_exp = e.data;
                end
            end
        end
        tick();
        wb_en   = 1'b0;
        wb_rd   = '0;
        wb_data = '0;
    endtask

    task automatic check_done(input int cc, input logic exp_to);
        chk("done", 64'(done), 64'(1));
        chk("busy_done", 64'(busy), 64'(0));
        chk("pass", 64'(pass), 64'(!exp_to && m_err == 0));
        chk("timed_out", 64'(timed_out), 64'(exp_to));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("cycle_count", 64'(cycle_count), 64'(cc));
        chk("mm_valid", 64'(mm_valid), 64'(m_mm_v));
        if (m_mm_v) begin
            chk("mm_rd", 64'(mm_rd), 64'(m_mm_rd));
            chk("mm_got", 64'(mm_got), 64'(m_mm_got));
            chk("mm_exp", 64'(mm_exp), 64'(m_mm_exp));
        end
    endtask

    task automatic load8;
        for (int i = 0; i < 8; i++) push_exp(RA_W'(i + 1), tdata[i], '1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; clear = 1'b0; exp_valid = 1'b0; exp_rd = '0; exp_data = '0;
        exp_mask = '1; start = 1'b0; timeout = '0; wb_en = 1'b0; wb_rd = '0;
        wb_data = '0;
        model_clear();
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_pass", 64'(pass), 64'(0));
        chk("rst_err", 64'(err_count), 64'(0));
        chk("rst_cyc", 64'(cycle_count), 64'(0));
        chk("rst_mm", 64'(mm_valid), 64'(0));
        chk("rst_ready", 64'(exp_ready), 64'(1));

        // 1: eight matching writebacks
        load8();
        do_start();
        chk("t1_busy", 64'(busy), 64'(1));
        for (int i = 0; i < 8; i++) begin
            chk("t1_not_done", 64'(done), 64'(0));
            wb(RA_W'(i + 1), tdata[i]);
        end
        check_done(8, 1'b0);
        chk("t1_ready_done", 64'(exp_ready), 64'(0));
        do_start();
        chk("t1_start_in_done", 64'(done), 64'(1));
        chk("t1_hold_cyc", 64'(cycle_count), 64'(8));
        do_clear();
        chk("clr_done", 64'(done), 64'(0));
        chk("clr_pass", 64'(pass), 64'(0));
        chk("clr_ready", 64'(exp_ready), 64'(1));

        // 2: seventh writeback corrupted
        load8();
        do_start();
        for (int i = 0; i < 8; i++) wb(RA_W'(i + 1), (i == 6) ? 32'h1 : tdata[i]);
        check_done(8, 1'b0);
        chk("t2_err_one", 64'(err_count), 64'(1));
        do_clear();

        // 3: timeout with an entry still pending
        push_exp(5'd10, 32'd100, '1);
        push_exp(5'd11, 32'd200, '1);
        timeout = 16'd5;
        do_start();
        wb(5'd10, 32'd100);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("t3_idle_cycles", 64'(n), 64'(4));
        check_done(5, 1'b1);
        do_clear();

        // 3b: last pop on the timeout cycle wins
        timeout = 16'd1;
        push_exp(5'd12, 32'd7, '1);
        do_start();
        wb(5'd12, 32'd7);
        check_done(1, 1'b0);
        timeout = '0;
        do_clear();

        // 4: writes to x0 are ignored
        push_exp(5'd1, 32'd11, '1);
        push_exp(5'd2, 32'd22, '1);
        push_exp(5'd3, 32'd33, '1);
        do_start();
        wb(5'd1, 32'd11);
        wb(5'd0, 32'hDEAD);
        wb(5'd2, 32'd22);
        wb(5'd0, 32'hDEAD);
        chk("t4_busy", 64'(busy), 64'(1));
        wb(5'd3, 32'd33);
        check_done(5, 1'b0);
        do_clear();

        // 5: fill the queue, overflow push dropped, clear mid-RUN
        for (int i = 0; i < DEPTH; i++) push_exp(RA_W'(i + 1), XLEN'(i * 3), '1);
        push_exp(5'd20, 32'd999, '1);
        do_start();
        wb(5'd1, 32'd0);
        wb(5'd2, 32'd12345);
        chk("t5_err_mid", 64'(err_count), 64'(m_err));
        chk("t5_busy", 64'(busy), 64'(1));
        do_clear();
        chk("t5_clr_busy", 64'(busy), 64'(0));
        chk("t5_clr_err", 64'(err_count), 64'(0));
        chk("t5_clr_mm", 64'(mm_valid), 64'(0));
        chk("t5_clr_cyc", 64'(cycle_count), 64'(0));
        do_start();
        check_done(0, 1'b0);
        do_clear();

        // 6: push in the same cycle as start
        chk("t6_ready", 64'(exp_ready), 64'(1));
        exp_valid = 1'b1; exp_rd = 5'd4; exp_data = 32'd44; exp_mask = '1; start = 1'b1;
        mq.push_back('{rd: 5'd4, data: 32'd44, mask: '1});
        tick();
        exp_valid = 1'b0; start = 1'b0;
        chk("t6_busy", 64'(busy), 64'(1));
        wb(5'd4, 32'd44);
        check_done(1, 1'b0);
        do_clear();

`ifdef RV_SB_MASK_EN
        // 7: masked compare
        push_exp(5'd9, 32'h1234_0000, 32'hFFFF_0000);
        push_exp(5'd9, 32'h1234_0000, 32'hFFFF_0000);
        do_start();
        wb(5'd9, 32'h1234_ABCD);
        chk("t7_err_masked", 64'(err_count), 64'(0));
        wb(5'd9, 32'h1235_ABCD);
        check_done(2, 1'b0);
        do_clear();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_wb_scoreboard.md
Name: rv_wb_scoreboard

Overview:
- Synthesizable self-checking scoreboard for the single-cycle RISC-V core.
- Holds an in-order queue of expected register writebacks (rd, value) and compares each retired register write against the queue head.
- Reports pass/fail, error count, cycle count, first-mismatch detail and timeout.
- Sits beside the core's register-file write port; moves directed-test checking from end-of-run register peeking into hardware.

Parameters:
- XLEN, 32, data width of writeback and expected values
- RA_W, 5, register address width
- DEPTH, 16, expected-entry queue depth (power of two, >=2)
- CNT_W, 8, width of error counter (saturating)
- CYC_W, 16, width of cycle counter and timeout compare

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- clear  in  1  synchronous flush; returns to IDLE
- exp_valid  in  1  expected-entry push request
- exp_ready  out  1  push accepted when exp_valid && exp_ready
- exp_rd  in  RA_W  expected destination register
- exp_data  in  XLEN  expected write value
- start  in  1  begin checking (sampled in IDLE only)
- timeout  in  CYC_W  max RUN cycles; 0 = no timeout
- wb_en  in  1  core RegWrite
- wb_rd  in  RA_W  core destination register
- wb_data  in  XLEN  core writeback data
- busy  out  1  state==RUN
- done  out  1  state==DONE
- pass  out  1  valid when done
- timed_out  out  1  DONE reached via timeout
- err_count  out  CNT_W  mismatches, saturating at all-ones
- cycle_count  out  CYC_W  RUN cycles elapsed, saturating
- mm_valid  out  1  first mismatch captured
- mm_rd  out  RA_W  rd of first mismatch (core side)
- mm_got  out  XLEN  core data of first mismatch
- mm_exp  out  XLEN  expected data of first mismatch

Behaviour:
- States: IDLE, RUN, DONE. Reset and clear both force IDLE, empty queue, all outputs 0. clear has priority over every other input except reset.
- exp_ready = (state==IDLE) && !full. Push writes the tail. Full means DEPTH entries. Pushes in RUN/DONE are ignored because exp_ready is 0.
- IDLE -> RUN on start. A push in the same cycle as start is included in the queue.
- start with an empty queue (including that cycle's push) -> DONE next cycle with pass=1, cycle_count=0.
- RUN, every cycle: cycle_count increments, saturating.
- RUN, write event (wb_en && wb_rd!=0): pops the head and compares wb_rd==exp_rd and wb_data==exp_data.
  - On mismatch: err_count++ (saturating).
  - If mm_valid==0, latch mm_rd/mm_got/mm_exp and set mm_valid. Later mismatches do not overwrite.
- wb_en with wb_rd==0 is ignored; no pop.
- Queue becomes empty after a pop -> DONE next cycle, pass=(err_count==0 including this compare), timed_out=0.
- Timeout: timeout!=0 && cycle_count==timeout-1 while RUN with entries still pending -> DONE, timed_out=1, pass=0. If the final pop and timeout occur in the same cycle, the pop wins (timed_out=0).
- DONE holds all outputs until clear or reset. start in DONE is ignored.
- Combinational compare; registered outputs. done asserts 1 cycle after the last pop.

Optional Feature:
- Macro: RV_SB_MASK_EN.
- Defined: adds input exp_mask [XLEN-1:0], stored per entry. Data compare becomes ((wb_data ^ exp_data) & exp_mask)==0. rd is always compared in full. mm_exp reports exp_data unmasked.
- Undefined: no exp_mask port; exact compare.

Test Plan:
- Push (1,5),(2,10),(3,0xFFFFFFF0),(4,3),(5,15),(6,0xFFFFFFFB),(7,0),(8,15); start; drive matching writebacks one per cycle -> done one cycle after 8th, pass=1, err_count=0, cycle_count=8.
- Same queue, 7th writeback data=0x00000001 -> pass=0, err_count=1, mm_valid=1, mm_rd=7, mm_got=1, mm_exp=0.
- Push 2 entries, timeout=5, only 1 writeback -> DONE at RUN cycle 5, timed_out=1, pass=0.
- Interleave wb_en with wb_rd=0 (data 0xDEAD) between valid writes -> ignored, pass=1.
- Fill 16 entries -> exp_ready=0, 17th push dropped. Start, apply clear mid-RUN -> IDLE, queue empty, err_count=0.
- With RV_SB_MASK_EN: entry (9,0x12340000, mask 0xFFFF0000), wb 0x1234ABCD -> pass=1.
